// File: rtl/mc_io_resp_if.sv
// IO bus between the mc_top IO master and mc_io_resp: strobe/we/addr/data out, ack/read data back.
// The master holds io_stb_i until it sees the one-cycle io_ack_o.
interface mc_io_resp_if;
    logic        io_stb_i;
    logic        io_we_i;
    logic [31:0] io_addr_i;
    logic [31:0] io_data_i;
    logic        io_ack_o;
    logic [31:0] io_data_o;

    modport master (
        output io_stb_i, io_we_i, io_addr_i, io_data_i,
        input  io_ack_o, io_data_o
    );

    modport slave (
        input  io_stb_i, io_we_i, io_addr_i, io_data_i,
        output io_ack_o, io_data_o
    );
endinterface

// File: rtl/mc_io_resp.sv
// GPIO + timer register responder; ack one cycle after WAIT_CYCLES+1 edges from strobe sampling.
// Dropping the strobe during wait states aborts the transfer; misses still ack so the bus never hangs.
module mc_io_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    mc_io_resp_if.slave bus,
    input  logic [7:0]  gpio_i,
    output logic [7:0]  gpio_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic        we_q;
    logic [31:2] addr_q;
    logic [31:0] wdat_q;
    logic [31:0] rdat_q;
    logic        ack_q;
    logic [31:0] dout_q;

    logic [7:0]  sync1_q, sync2_q;
    logic [7:0]  gpio_q, gpio_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        en_q, en_d, ien_q, ien_d, pend_q, pend_d;
    logic        irq_q;

    logic        x_we;
    logic [31:2] x_addr;
    logic [31:0] x_dat;
    logic        enter_ack, hit, wr_en, wrap;
    logic [1:0]  sel;
    logic [31:0] rd_mux;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^bus.io_addr_i[1:0];

    // With zero wait states the access completes on the sampling edge, so use the live bus.
    always_comb begin
        x_we   = (state_q == IDLE) ? bus.io_we_i          : we_q;
        x_addr = (state_q == IDLE) ? bus.io_addr_i[31:2]  : addr_q;
        x_dat  = (state_q == IDLE) ? bus.io_data_i        : wdat_q;
        enter_ack = 1'b0;
        case (state_q)
            IDLE:    enter_ack = bus.io_stb_i && (WAIT_CYCLES == 0);
            WAIT:    enter_ack = bus.io_stb_i && (wcnt_q == 4'd1);
            default: enter_ack = 1'b0;
        endcase
        hit   = (x_addr[31:4] == BASE_ADDR[31:4]);
        sel   = x_addr[3:2];
        wr_en = enter_ack && x_we && hit;
        case (sel)
            2'd0:    rd_mux = {24'b0, gpio_q};
            2'd1:    rd_mux = {24'b0, sync2_q};
            2'd2:    rd_mux = tcnt_q;
            default: rd_mux = {29'b0, pend_q, ien_q, en_q};
        endcase
    end

    always_comb begin
        wrap   = en_q && (tcnt_q == 32'hFFFF_FFFF);
        tcnt_d = en_q ? tcnt_q + 32'd1 : tcnt_q;
        gpio_d = gpio_q;
        en_d   = en_q;
        ien_d  = ien_q;
        pend_d = pend_q;
        if (wr_en) begin
            case (sel)
                2'd0: gpio_d = x_dat[7:0];
                2'd2: tcnt_d = x_dat;
                2'd3: begin
                    en_d  = x_dat[0];
                    ien_d = x_dat[1];
                    if (x_dat[2]) pend_d = 1'b0;
                end
                default: ;
            endcase
        end
        // A wrap beats a same-cycle clear, but a counter write suppresses the wrap.
        if (wrap && !(wr_en && sel == 2'd2)) pend_d = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            ack_q  <= 1'b0;
            dout_q <= '0;
            if (enter_ack) rdat_q <= (hit && !x_we) ? rd_mux : '0;
            case (state_q)
                IDLE: if (bus.io_stb_i) begin
                    we_q    <= bus.io_we_i;
                    addr_q  <= bus.io_addr_i[31:2];
                    wdat_q  <= bus.io_data_i;
                    wcnt_q  <= 4'(WAIT_CYCLES);
                    state_q <= (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
                WAIT: begin
                    wcnt_q <= wcnt_q - 4'd1;
                    if (!bus.io_stb_i)        state_q <= IDLE;
                    else if (wcnt_q == 4'd1)  state_q <= ACK;
                end
                ACK: begin
                    ack_q   <= 1'b1;
                    dout_q  <= rdat_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            gpio_q  <= '0;
            tcnt_q  <= '0;
            en_q    <= 1'b0;
            ien_q   <= 1'b0;
            pend_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            gpio_q  <= gpio_d;
            tcnt_q  <= tcnt_d;
            en_q    <= en_d;
            ien_q   <= ien_d;
            pend_q  <= pend_d;
            irq_q   <= pend_q & ien_q;
        end
    end

    assign bus.io_ack_o  = ack_q;
    assign bus.io_data_o = dout_q;
    assign gpio_o        = gpio_q;
    assign irq_o         = irq_q;
endmodule
